multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle sequencer for the RV32 datapath: drives one instruction at a time through fetch, decode, execute, memory and writeback over several clock cycles. The sequencer replaces the single-cycle opcode decoder and controls PC, IR, register-file, ALU and data-memory enables. It stalls on a shared memory port through a ready handshake. It halts with `Exit` on any unsupported opcode.

## Interface
Parameters:
- `CNT_W`, 32, width of retired-instruction counter

Ports:
- `Clock`  in  1  rising-edge clock
- `Reset`  in  1  asynchronous, active-high reset
- `Opcode`  in  7  IR[6:0]; sampled only in DECODE
- `Zero`  in  1  ALU zero flag; sampled only in BRANCH
- `MemReady`  in  1  memory port completes current request this cycle
- `PCWrite`  out  1  load PC (PC+4 in FETCH, branch target in BRANCH)
- `IRWrite`  out  1  load instruction register
- `MemRead`  out  1  memory read request (fetch or load)
- `MemWrite`  out  1  memory write request (store)
- `MemToReg`  out  1  writeback source: 1 = memory data, 0 = ALU result
- `ALUSrc`  out  1  ALU operand B: 1 = immediate, 0 = rs2
- `RegWrite`  out  1  register-file write enable
- `Branch`  out  1  PC mux selects branch target
- `ALUOp`  out  2  00 add, 01 sub/compare, 10 R-funct, 11 I-funct
- `Exit`  out  1  halted; sticky until reset
- `InstrCount`  out  CNT_W  retired instructions

## Operation
- Opcode classes: 0110011 R, 0010011 I, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH. Every other value, including X/Z in simulation, is ILLEGAL.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, HALT.
- FETCH: MemRead=1. IRWrite=PCWrite=MemReady. Go to DECODE when MemReady=1, otherwise hold.
- DECODE: no enables asserted. Dispatch: R→EXEC_R, I→EXEC_I, LOAD/STORE→MEM_ADDR, BRANCH→BRANCH, ILLEGAL→HALT.
- EXEC_R: ALUSrc=0, ALUOp=10. Next state WB_ALU.
- EXEC_I: ALUSrc=1, ALUOp=11. Next state WB_ALU.
- WB_ALU: RegWrite=1, MemToReg=0. Retire; next state FETCH.
- MEM_ADDR: ALUSrc=1, ALUOp=00. Next state MEM_RD for a load, MEM_WR for a store. The class is latched in DECODE and not resampled.
- MEM_RD: MemRead=1. Go to WB_MEM on MemReady, otherwise hold.
- WB_MEM: RegWrite=1, MemToReg=1. Retire; next state FETCH.
- MEM_WR: MemWrite=1. Retire and go to FETCH on MemReady, otherwise hold.
- BRANCH: ALUSrc=0, ALUOp=01, Branch=1, PCWrite=Zero (beq). Retire; next state FETCH.
- HALT: Exit=1, all other enables 0. Remain in HALT until Reset; Opcode and MemReady are ignored.
- Outputs not listed for a state are 0.
- MemRead and MemWrite are never asserted together. A request, once raised, stays high until the cycle in which MemReady=1.
- Retire: InstrCount increments by 1 on the clock edge that leaves WB_ALU, WB_MEM, BRANCH, or MEM_WR with MemReady=1. The counter wraps modulo 2^CNT_W without flagging. ILLEGAL instructions are not counted.

## Timing
- Reset asserted: state goes to FETCH, the class latch clears, and InstrCount=0 asynchronously. All outputs are forced to 0 while Reset=1, including Exit and MemRead.
- Reset asserted mid-request abandons the transaction with no completion. First MemRead=1 appears in the first cycle after Reset deasserts.
- Outputs are combinational from state. The only Mealy terms are IRWrite/PCWrite in FETCH (from MemReady) and PCWrite in BRANCH (from Zero).
- Latency with MemReady tied high, counted in cycles from entering FETCH to the retire edge: R/I 4, STORE 4, LOAD 5, BRANCH 3.
- Each wait cycle with MemReady=0 adds exactly one cycle in FETCH, MEM_RD or MEM_WR.

## Structure
- Shared package `control_pkg` holds:
  - state enum;
  - opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH;
  - ALUOp constants ALU_ADD, ALU_SUB, ALU_RFUNCT, ALU_IFUNCT;
  - instruction-class enum.
- One sub-module, `opcode_class_decode`: a combinational map from Opcode to instruction class, with ILLEGAL as the default.
- The top level contains the state register, class latch, output decode and counter.

## Test plan
- Zero-wait R-type (0110011), MemReady=1: states FETCH, DECODE, EXEC_R, WB_ALU. RegWrite=1 only in cycle 4 with ALUOp=10. InstrCount 0→1.
- LOAD (0000011) with MemReady low for 2 cycles in MEM_RD: MemRead held 3 cycles, then WB_MEM with RegWrite=1 and MemToReg=1. Total 7 cycles; InstrCount +1.
- BRANCH (1100011), first with Zero=1 then with Zero=0: PCWrite=1 and Branch=1 in the BRANCH cycle for Zero=1; PCWrite=0 and Branch=1 for Zero=0. 3 cycles each.
- STORE (0100011) with FETCH wait of 1 cycle: IRWrite=0 then 1. MemWrite=1 only in MEM_WR and never together with MemRead. Retire on MemReady.
- Opcode 1111111, then Opcode=X: next state HALT with Exit=1 and all enables 0 for 20+ cycles. InstrCount unchanged; Reset returns to FETCH with Exit=0.
- Reset asserted mid-MEM_RD, plus a counter preset near 2^CNT_W−1 (CNT_W=4, 16 retires): immediate zero outputs and count=0 on reset. Counter reads 15→0 on wrap.

Source files
------------

// File: rtl/control_pkg.sv
// Shared types and constants for the multi-cycle RV32 control sequencer.
package control_pkg;

    // Sequencer states, one per phase of instruction processing.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_HALT     = 4'd10
    } state_t;

    // Major opcodes (IR[6:0]) understood by the sequencer.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // ALU operation selects driven on ALUOp.
    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_RFUNCT = 2'b10;
    localparam logic [1:0] ALU_IFUNCT = 2'b11;

    // Instruction classes; ILLEGAL is zero so a cleared latch reads as "nothing valid".
    typedef enum logic [2:0] {
        CLS_ILLEGAL = 3'd0,
        CLS_R       = 3'd1,
        CLS_I       = 3'd2,
        CLS_LOAD    = 3'd3,
        CLS_STORE   = 3'd4,
        CLS_BRANCH  = 3'd5
    } instr_class_t;

    // Complete datapath control word produced each cycle.
    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_write;
        logic       branch;
        logic [1:0] alu_op;
        logic       halted;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode-to-class map; anything unrecognised (including X/Z) is ILLEGAL.
module opcode_class_decode
    import control_pkg::*;
(
    input  logic [6:0]   opcode,
    output instr_class_t instr_class
);

    // Classify the opcode; unmatched values fall through to the ILLEGAL default.
    always_comb begin
        // NOTE: default assigned first so every path drives instr_class and no latch is inferred.
        instr_class = CLS_ILLEGAL;
        case (opcode)
            OP_R:      instr_class = CLS_R;
            OP_I:      instr_class = CLS_I;
            OP_LOAD:   instr_class = CLS_LOAD;
            OP_STORE:  instr_class = CLS_STORE;
            OP_BRANCH: instr_class = CLS_BRANCH;
            default:   instr_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 sequencer: steps one instruction through fetch, decode,
// execute, memory and writeback, stalling on MemReady and halting on ILLEGAL opcodes.
module multicycle_control
    import control_pkg::*;
#(
    parameter int CNT_W = 32
)
(
    input  logic             Clock,
    input  logic             Reset,
    input  logic [6:0]       Opcode,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic             ALUSrc,
    output logic             RegWrite,
    output logic             Branch,
    output logic [1:0]       ALUOp,
    output logic             Exit,
    output logic [CNT_W-1:0] InstrCount
);

    state_t       state;
    state_t       next_state;
    instr_class_t decoded_cls;
    instr_class_t cls_q;
    logic         retire;
    ctrl_t        ctrl;
    ctrl_t        ctrl_out;

    opcode_class_decode u_decode (
        .opcode      (Opcode),
        .instr_class (decoded_cls)
    );

    // State register; reset returns to FETCH and abandons any pending memory request.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= ST_FETCH;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so all flops update together.
            state <= next_state;
        end
    end

    // Class latch: captured in DECODE so MEM_ADDR routes on the fetched instruction, not a later Opcode.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            cls_q <= CLS_ILLEGAL;
        end else if (state == ST_DECODE) begin
            cls_q <= decoded_cls;
        end
    end

    // Next-state logic; waits hold in FETCH, MEM_RD and MEM_WR until MemReady.
    always_comb begin
        next_state = state;
        case (state)
            ST_FETCH: begin
                if (MemReady) next_state = ST_DECODE;
            end
            ST_DECODE: begin
                case (decoded_cls)
                    CLS_R:                next_state = ST_EXEC_R;
                    CLS_I:                next_state = ST_EXEC_I;
                    CLS_LOAD, CLS_STORE:  next_state = ST_MEM_ADDR;
                    CLS_BRANCH:           next_state = ST_BRANCH;
                    default:              next_state = ST_HALT;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: next_state = ST_WB_ALU;
            ST_MEM_ADDR: begin
                if (cls_q == CLS_LOAD)       next_state = ST_MEM_RD;
                else if (cls_q == CLS_STORE) next_state = ST_MEM_WR;
                else                         next_state = ST_HALT;
            end
            ST_MEM_RD: begin
                if (MemReady) next_state = ST_WB_MEM;
            end
            ST_MEM_WR: begin
                if (MemReady) next_state = ST_FETCH;
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH: next_state = ST_FETCH;
            ST_HALT: next_state = ST_HALT;
            default: next_state = ST_HALT;
        endcase
    end

    // Retire strobe: high in the last cycle of every legal instruction.
    always_comb begin
        retire = 1'b0;
        case (state)
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH: retire = 1'b1;
            ST_MEM_WR:                       retire = MemReady;
            default:                         retire = 1'b0;
        endcase
    end

    // Retired-instruction counter; wraps silently at 2^CNT_W.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            InstrCount <= '0;
        end else if (retire) begin
            InstrCount <= InstrCount + CNT_W'(1);
        end
    end

    // Output decode: Moore by state, with MemReady-driven fetch loads and Zero-driven branch taken.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            ST_FETCH: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = MemReady;
                ctrl.pc_write = MemReady;
            end
            ST_EXEC_R: begin
                ctrl.alu_src = 1'b0;
                ctrl.alu_op  = ALU_RFUNCT;
            end
            ST_EXEC_I: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_IFUNCT;
            end
            ST_MEM_ADDR: begin
                ctrl.alu_src = 1'b1;
                ctrl.alu_op  = ALU_ADD;
            end
            ST_MEM_RD: ctrl.mem_read  = 1'b1;
            ST_MEM_WR: ctrl.mem_write = 1'b1;
            ST_WB_ALU: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b0;
            end
            ST_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            ST_BRANCH: begin
                ctrl.alu_src  = 1'b0;
                ctrl.alu_op   = ALU_SUB;
                ctrl.branch   = 1'b1;
                ctrl.pc_write = Zero;
            end
            ST_HALT: ctrl.halted = 1'b1;
            default: ctrl = CTRL_IDLE;
        endcase
    end

    // While Reset is held the state already reads FETCH, so the fetch request is masked here.
    assign ctrl_out = Reset ? CTRL_IDLE : ctrl;

    assign PCWrite  = ctrl_out.pc_write;
    assign IRWrite  = ctrl_out.ir_write;
    assign MemRead  = ctrl_out.mem_read;
    assign MemWrite = ctrl_out.mem_write;
    assign MemToReg = ctrl_out.mem_to_reg;
    assign ALUSrc   = ctrl_out.alu_src;
    assign RegWrite = ctrl_out.reg_write;
    assign Branch   = ctrl_out.branch;
    assign ALUOp    = ctrl_out.alu_op;
    assign Exit     = ctrl_out.halted;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded into an
// expected per-cycle control trace from the phase rules, then replayed against the DUT.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BRANCH = 4;

    // Control word bit masks, order {PCWrite,IRWrite,MemRead,MemWrite,MemToReg,ALUSrc,RegWrite,Branch,ALUOp[1:0],Exit}
    localparam logic [10:0] B_PCW  = 11'b100_0000_0000;
    localparam logic [10:0] B_IRW  = 11'b010_0000_0000;
    localparam logic [10:0] B_MRD  = 11'b001_0000_0000;
    localparam logic [10:0] B_MWR  = 11'b000_1000_0000;
    localparam logic [10:0] B_M2R  = 11'b000_0100_0000;
    localparam logic [10:0] B_ASRC = 11'b000_0010_0000;
    localparam logic [10:0] B_RW   = 11'b000_0001_0000;
    localparam logic [10:0] B_BR   = 11'b000_0000_1000;
    localparam logic [10:0] B_EXIT = 11'b000_0000_0001;

    logic             Clock = 1'b0;
    logic             Reset;
    logic [6:0]       Opcode;
    logic             Zero;
    logic             MemReady;
    logic             PCWrite, IRWrite, MemRead, MemWrite, MemToReg;
    logic             ALUSrc, RegWrite, Branch, Exit;
    logic [1:0]       ALUOp;
    logic [CNT_W-1:0] InstrCount;
    logic [10:0]      obs;

    multicycle_control #(.CNT_W(CNT_W)) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .Opcode     (Opcode),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemToReg   (MemToReg),
        .ALUSrc     (ALUSrc),
        .RegWrite   (RegWrite),
        .Branch     (Branch),
        .ALUOp      (ALUOp),
        .Exit       (Exit),
        .InstrCount (InstrCount)
    );

    assign obs = {PCWrite, IRWrite, MemRead, MemWrite, MemToReg, ALUSrc,
                  RegWrite, Branch, ALUOp, Exit};

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic        mr;
        logic        z;
        logic [6:0]  op;
        logic [10:0] exp;
    } step_t;

    step_t       trace[$];
    int          n_compared   = 0;
    int          n_mismatched = 0;
    int unsigned model_count  = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [10:0] aop(input logic [1:0] a);
        return {8'b0, a, 1'b0};
    endfunction

    function automatic logic [6:0] rnd_op();
        return 7'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    task automatic push(input logic mr, input logic z, input logic [6:0] op, input logic [10:0] exp);
        step_t s;
        s.mr  = mr;
        s.z   = z;
        s.op  = op;
        s.exp = exp;
        trace.push_back(s);
    endtask

    // Fetch phase: request held through waits, IR/PC load only in the ready cycle; then decode.
    task automatic add_fetch_decode(input int fetch_waits, input logic [6:0] op);
        for (int i = 0; i < fetch_waits; i++) push(1'b0, rnd_bit(), rnd_op(), B_MRD);
        push(1'b1, rnd_bit(), rnd_op(), B_MRD | B_IRW | B_PCW);
        push(rnd_bit(), rnd_bit(), op, 11'b0);
    endtask

    // Whole instruction trace; zsel 0/1 forces Zero in the branch cycle, anything else randomises it.
    task automatic add_instr(input int kind, input int fetch_waits, input int mem_waits, input int zsel);
        logic z;
        case (kind)
            K_R: begin
                add_fetch_decode(fetch_waits, OPC_R);
                push(rnd_bit(), rnd_bit(), rnd_op(), aop(2'b10));
                push(rnd_bit(), rnd_bit(), rnd_op(), B_RW);
            end
            K_I: begin
                add_fetch_decode(fetch_waits, OPC_I);
                push(rnd_bit(), rnd_bit(), rnd_op(), B_ASRC | aop(2'b11));
                push(rnd_bit(), rnd_bit(), rnd_op(), B_RW);
            end
            K_LOAD: begin
                add_fetch_decode(fetch_waits, OPC_LOAD);
                push(rnd_bit(), rnd_bit(), rnd_op(), B_ASRC | aop(2'b00));
                for (int i = 0; i < mem_waits; i++) push(1'b0, rnd_bit(), rnd_op(), B_MRD);
                push(1'b1, rnd_bit(), rnd_op(), B_MRD);
                push(rnd_bit(), rnd_bit(), rnd_op(), B_RW | B_M2R);
            end
            K_STORE: begin
                add_fetch_decode(fetch_waits, OPC_STORE);
                push(rnd_bit(), rnd_bit(), rnd_op(), B_ASRC | aop(2'b00));
                for (int i = 0; i < mem_waits; i++) push(1'b0, rnd_bit(), rnd_op(), B_MWR);
                push(1'b1, rnd_bit(), rnd_op(), B_MWR);
            end
            default: begin
                add_fetch_decode(fetch_waits, OPC_BRANCH);
                z = (zsel == 0) ? 1'b0 : (zsel == 1) ? 1'b1 : rnd_bit();
                push(rnd_bit(), z, rnd_op(), B_BR | aop(2'b01) | (z ? B_PCW : 11'b0));
            end
        endcase
    endtask

    // Replay the queued trace: drive just after the rising edge, compare on the falling edge.
    task automatic play(input string name);
        for (int i = 0; i < trace.size(); i++) begin
            MemReady = trace[i].mr;
            Zero     = trace[i].z;
            Opcode   = trace[i].op;
            @(negedge Clock);
            check($sformatf("%s cyc%0d ctrl", name, i), 32'(obs), 32'(trace[i].exp));
            @(posedge Clock);
            #1;
        end
        trace.delete();
    endtask

    task automatic run_instr(input string name, input int kind, input int fw, input int mw, input int zsel);
        add_instr(kind, fw, mw, zsel);
        play(name);
        model_count++;
        check({name, " count"}, 32'(InstrCount), model_count % (1 << CNT_W));
    endtask

    // Assert reset mid-cycle, verify immediate quiet outputs and cleared count, release a cycle later.
    task automatic pulse_reset(input string name);
        MemReady = 1'b1;
        Zero     = 1'b1;
        Reset    = 1'b1;
        #1;
        check({name, " reset ctrl"}, 32'(obs), 32'd0);
        check({name, " reset count"}, 32'(InstrCount), 32'd0);
        model_count = 0;
        @(posedge Clock);
        #1;
        check({name, " reset held ctrl"}, 32'(obs), 32'd0);
        Reset = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        MemReady = 1'b1;
        Zero     = 1'b1;
        Opcode   = OPC_R;
        repeat (2) @(posedge Clock);
        #1;
        check("por ctrl", 32'(obs), 32'd0);
        check("por count", 32'(InstrCount), 32'd0);
        Reset = 1'b0;

        // Directed cases.
        run_instr("r_zero_wait", K_R, 0, 0, 2);
        run_instr("load_wait2", K_LOAD, 0, 2, 2);
        run_instr("beq_taken", K_BRANCH, 0, 0, 1);
        run_instr("beq_not_taken", K_BRANCH, 0, 0, 0);
        run_instr("store_fetch_wait1", K_STORE, 1, 0, 2);
        run_instr("i_zero_wait", K_I, 0, 0, 2);

        // Randomised mix; enough retires to wrap the 4-bit counter more than once.
        for (int n = 0; n < 40; n++) begin
            run_instr($sformatf("rnd%0d", n), int'($urandom_range(0, 4)),
                      int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 2);
        end

        // Reset in the middle of a stalled load read.
        add_fetch_decode(0, OPC_LOAD);
        push(1'b1, 1'b0, rnd_op(), B_ASRC | aop(2'b00));
        push(1'b0, 1'b0, rnd_op(), B_MRD);
        play("load_abort");
        MemReady = 1'b0;
        pulse_reset("load_abort");
        run_instr("after_abort", K_R, 0, 0, 2);

        // Unsupported opcode halts; sticky for 22 cycles regardless of inputs.
        add_fetch_decode(0, 7'b1111111);
        for (int i = 0; i < 22; i++) push(rnd_bit(), rnd_bit(), rnd_op(), B_EXIT);
        play("illegal_ff");
        check("illegal_ff count", 32'(InstrCount), model_count % (1 << CNT_W));
        pulse_reset("illegal_ff");
        run_instr("after_halt", K_LOAD, 1, 1, 2);

        // Unknown opcode is treated as illegal too.
        add_fetch_decode(0, 7'bxxxxxxx);
        for (int i = 0; i < 22; i++) push(rnd_bit(), rnd_bit(), rnd_op(), B_EXIT);
        play("illegal_x");
        check("illegal_x count", 32'(InstrCount), model_count % (1 << CNT_W));
        pulse_reset("illegal_x");
        run_instr("final", K_STORE, 0, 2, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
